// File: rtl/rr_arbiter_pkg.sv
// Shared types for the round-robin / fixed-priority arbiter.
//   state_e : arbiter FSM states (IDLE, BUSY)
//   mode_e  : arbitration mode sampled when a grant is issued
package arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic {
        FIXED = 1'b0,   // highest set index wins
        RR    = 1'b1    // lowest set index at/above the rotating pointer wins
    } mode_e;

endpackage

// File: rtl/rr_arbiter_if.sv
// Requester-side bus of the arbiter.
//   master : drives mode, request_vec, done; observes grant outputs
//   slave  : the arbiter itself
//   mode         arbitration mode (FIXED / RR)
//   request_vec  one request bit per requester
//   done         holder releases its grant
//   grant_valid  a grant is held
//   granted_idx  index of the holder (0 when idle)
//   grant_onehot one-hot form of granted_idx (0 when idle)
//   error        last IDLE sample saw no request
//   timeout      one-cycle pulse on a forced release
interface rr_arbiter_if #(parameter int W = 4);
    import arbiter_pkg::*;

    localparam int IW = $clog2(W);

    mode_e          mode;
    logic [W-1:0]   request_vec;
    logic           done;
    logic           grant_valid;
    logic [IW-1:0]  granted_idx;
    logic [W-1:0]   grant_onehot;
    logic           error;
    logic           timeout;

    modport master (
        output mode, request_vec, done,
        input  grant_valid, granted_idx, grant_onehot, error, timeout
    );

    modport slave (
        input  mode, request_vec, done,
        output grant_valid, granted_idx, grant_onehot, error, timeout
    );

endinterface

// File: rtl/rr_arbiter_pick.sv
// Combinational winner selection.
//   request_vec : request bits
//   ptr         : round-robin start position
//   mode        : FIXED -> highest set index, RR -> lowest set index at or
//                 above ptr, wrapping to the lowest set index overall
//   index       : selected requester (0 when nothing is requested)
//   any         : at least one request present
module rr_pick import arbiter_pkg::*; #(
    parameter int W  = 4,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  request_vec,
    input  logic [IW-1:0] ptr,
    input  mode_e         mode,
    output logic [IW-1:0] index,
    output logic          any
);

    logic          hit_hi;
    logic [IW-1:0] idx_hi;
    logic [IW-1:0] idx_lo;
    logic [IW-1:0] idx_top;

    always_comb begin
        hit_hi  = 1'b0;
        idx_hi  = '0;
        idx_lo  = '0;
        idx_top = '0;
        // Descending scan: the last hit is the lowest index, both overall
        // (wrap candidate) and within the region at/above ptr.
        for (int i = W - 1; i >= 0; i--) begin
            if (request_vec[i]) begin
                idx_lo = IW'(i);
                if (IW'(i) >= ptr) begin
                    idx_hi = IW'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        // Ascending scan: the last hit is the highest index.
        for (int i = 0; i < W; i++) begin
            if (request_vec[i]) idx_top = IW'(i);
        end
        if (mode == FIXED) index = idx_top;
        else               index = hit_hi ? idx_hi : idx_lo;
    end

    assign any = |request_vec;

endmodule

// File: rtl/rr_arbiter.sv
// Single-grant arbiter with fixed-priority and round-robin modes and a
// forced release after MAX_HOLD cycles.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : rr_arbiter_if slave port (requests in, grant state out)
// Every output is a flop; the grant is captured at the IDLE->BUSY edge and
// frozen until done or the hold limit.
module rr_arbiter import arbiter_pkg::*; #(
    parameter int W        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic        clock,
    input  logic        reset,
    rr_arbiter_if.slave bus
);

    localparam int IW = $clog2(W);
    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(W - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  oh_q, oh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;
    logic          to_q, to_d;

    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [IW-1:0] ptr_next;

    rr_pick #(.W(W), .IW(IW)) u_pick (
        .request_vec (bus.request_vec),
        .ptr         (ptr_q),
        .mode        (bus.mode),
        .index       (pick_idx),
        .any         (pick_any)
    );

    // Pointer moves just past the releasing holder (mod W, W need not be 2^n).
    assign ptr_next = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            oh_q    <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    idx_d   = pick_idx;
                    oh_d    = W'(1) << pick_idx;
                    cnt_d   = '0;
                    vld_d   = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                if (bus.done || cnt_q == HOLD_LAST) begin
                    // done on the limit edge is an ordinary release
                    state_d = IDLE;
                    ptr_d   = ptr_next;
                    idx_d   = '0;
                    oh_d    = '0;
                    cnt_d   = '0;
                    vld_d   = 1'b0;
                    to_d    = ~bus.done;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant_valid  = vld_q;
    assign bus.granted_idx  = idx_q;
    assign bus.grant_onehot = oh_q;
    assign bus.error        = err_q;
    assign bus.timeout      = to_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (W=4, MAX_HOLD=8). Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_rr_arbiter;
    import arbiter_pkg::*;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    rr_arbiter_if #(.W(4)) bus ();

    rr_arbiter #(.W(4), .MAX_HOLD(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [1:0] idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        chk({tag, "_vld"}, 32'(bus.grant_valid), 32'd1);
        chk({tag, "_idx"}, 32'(bus.granted_idx), 32'(idx));
        chk({tag, "_oh"},  32'(bus.grant_onehot), 32'(oh));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_vld"}, 32'(bus.grant_valid), 32'd0);
        chk({tag, "_idx"}, 32'(bus.granted_idx), 32'd0);
        chk({tag, "_oh"},  32'(bus.grant_onehot), 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.mode        = FIXED;
        bus.request_vec = 4'b0000;
        bus.done        = 1'b0;

        // reset state
        #2;
        chk_idle("rst");
        chk("rst_err", 32'(bus.error), 32'd0);
        chk("rst_to",  32'(bus.timeout), 32'd0);
        tick();
        reset = 1'b0;

        // idle with no requests: error every sample
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle0_err", 32'(bus.error), 32'd1);
            chk_idle("idle0");
        end

        // fixed priority: 1011 -> 3; holder drops its request, grant stays
        bus.mode = FIXED;
        bus.request_vec = 4'b1011;
        tick();
        chk_grant("fix", 2'd3);
        chk("fix_err", 32'(bus.error), 32'd0);
        bus.request_vec = 4'b0000;
        tick();
        chk_grant("fix_hold", 2'd3);
        bus.done = 1'b1;
        tick();
        chk_idle("fix_rel");
        chk("fix_rel_to",  32'(bus.timeout), 32'd0);
        chk("fix_rel_err", 32'(bus.error), 32'd0);
        bus.done = 1'b0;

        // round robin fairness from ptr=0: 0,1,2,3,0
        bus.mode = RR;
        bus.request_vec = 4'b1111;
        tick(); chk_grant("rr0", 2'd0); bus.done = 1'b1; tick(); chk_idle("rr0_rel"); bus.done = 1'b0;
        tick(); chk_grant("rr1", 2'd1); bus.done = 1'b1; tick(); chk_idle("rr1_rel"); bus.done = 1'b0;
        tick(); chk_grant("rr2", 2'd2); bus.done = 1'b1; tick(); chk_idle("rr2_rel"); bus.done = 1'b0;
        tick(); chk_grant("rr3", 2'd3); bus.done = 1'b1; tick(); chk_idle("rr3_rel"); bus.done = 1'b0;
        tick(); chk_grant("rr4", 2'd0); bus.done = 1'b1; tick(); chk_idle("rr4_rel"); bus.done = 1'b0;

        // ptr=1, 0100 -> 2; mode/request changes while busy are ignored
        bus.request_vec = 4'b0100;
        tick();
        chk_grant("mchg", 2'd2);
        bus.mode = FIXED;
        bus.request_vec = 4'b1000;
        tick();
        chk_grant("mchg_hold", 2'd2);
        bus.mode = RR;
        bus.request_vec = 4'b0000;
        bus.done = 1'b1;
        tick();
        chk_idle("mchg_rel");

        // done in IDLE is ignored
        tick();
        chk_idle("idle_done");
        chk("idle_done_err", 32'(bus.error), 32'd1);
        bus.done = 1'b0;

        // wrap and skip: ptr=3, 0110 -> 1, then ptr=2 so 0110 -> 2
        bus.request_vec = 4'b0110;
        tick();
        chk_grant("wrap", 2'd1);
        bus.request_vec = 4'b0000;
        bus.done = 1'b1;
        tick();
        chk_idle("wrap_rel");
        bus.done = 1'b0;
        bus.request_vec = 4'b0110;
        tick();
        chk_grant("ptr2", 2'd2);

        // timeout: 8 BUSY cycles, one-cycle pulse, ptr -> 3
        bus.request_vec = 4'b0000;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("to_busy_vld", 32'(bus.grant_valid), 32'd1);
            chk("to_busy_to",  32'(bus.timeout), 32'd0);
        end
        tick();
        chk_idle("to_rel");
        chk("to_pulse", 32'(bus.timeout), 32'd1);
        tick();
        chk("to_pulse_end", 32'(bus.timeout), 32'd0);
        chk("to_idle_err",  32'(bus.error), 32'd1);

        // ptr=3; done on the hold-limit edge is a normal release
        bus.request_vec = 4'b1111;
        tick();
        chk_grant("ptr3", 2'd3);
        bus.request_vec = 4'b0000;
        for (int i = 1; i <= 7; i++) tick();
        chk("lim_vld", 32'(bus.grant_valid), 32'd1);
        bus.done = 1'b1;
        tick();
        chk_idle("lim_rel");
        chk("lim_to", 32'(bus.timeout), 32'd0);
        bus.done = 1'b0;

        // move ptr away from 0, then reset while busy
        bus.request_vec = 4'b0010;
        tick();
        chk_grant("pre", 2'd1);
        bus.request_vec = 4'b0000;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.request_vec = 4'b1111;
        tick();
        chk_grant("pre2", 2'd2);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("arst");
        chk("arst_to", 32'(bus.timeout), 32'd0);
        reset = 1'b0;
        tick();
        chk_grant("post", 2'd0);
        chk("post_err", 32'(bus.error), 32'd0);
        bus.done = 1'b1;
        tick();
        chk_idle("post_rel");
        chk("post_to", 32'(bus.timeout), 32'd0);
        bus.done = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter W, default 4, number of requesters; legal range 2..32.
REQ-002 Parameter MAX_HOLD, default 16, maximum cycles a grant may be held before forced release; legal range 2..255.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mode  input  1  arbitration mode: 0 = fixed priority (highest index wins), 1 = round robin.
REQ-006 request_vec  input  W  one request bit per requester.
REQ-007 done  input  1  grant holder releases the grant; meaningful only while grant_valid=1.
REQ-008 grant_valid  output  1  a grant is currently held.
REQ-009 granted_idx  output  $clog2(W)  index of current grant holder; 0 when grant_valid=0.
REQ-010 grant_onehot  output  W  one-hot form of granted_idx; all zero when grant_valid=0.
REQ-011 error  output  1  registered: no request was present on the last IDLE sample.
REQ-012 timeout  output  1  single-cycle pulse on a forced release.

Function
REQ-013 The FSM shall have exactly two states: IDLE and BUSY.
REQ-014 In IDLE, on a rising edge with request_vec != 0, the FSM shall enter BUSY and register the selected index, so that grant_valid=1 in the first cycle after the sampling edge (latency 1).
REQ-015 In IDLE, on a rising edge with request_vec == 0, the FSM shall remain in IDLE and register error=1; any other edge shall register error=0.
REQ-016 Mode 0 selection shall be the highest set index of request_vec.
REQ-017 Mode 1 selection shall be the lowest set index at or above pointer ptr, wrapping from W-1 to 0.
REQ-018 mode shall be sampled only on the IDLE->BUSY edge; changes while BUSY have no effect on the held grant.
REQ-019 In BUSY, granted_idx and grant_onehot shall stay constant regardless of request_vec, including deassertion of the holder's own request bit.
REQ-020 In BUSY, done=1 at a rising edge shall return the FSM to IDLE, so that grant_valid=0 in the next cycle; done while in IDLE shall be ignored.
REQ-021 A hold counter shall clear on entry to BUSY and increment on each BUSY cycle without done.
REQ-022 When the counter reaches MAX_HOLD-1 without done, the FSM shall return to IDLE, and timeout shall be 1 for exactly the following cycle.
REQ-023 done and the timeout condition on the same edge shall count as a normal release, with timeout=0.
REQ-024 On every release (done or timeout), ptr shall update to (granted_idx+1) mod W in both modes; ptr shall not change otherwise.
REQ-025 After a release, at least one IDLE cycle shall occur before the next grant (no back-to-back BUSY).

Reset
REQ-026 While reset=1, outputs shall immediately read: state=IDLE, ptr=0, hold counter=0, grant_valid=0, granted_idx=0, grant_onehot=0, error=0, timeout=0.
REQ-027 Reset asserted while in BUSY shall drop the grant asynchronously, with no timeout pulse and no ptr update.
REQ-028 The first rising edge after reset deassertion shall be treated as a normal IDLE sample.

Structure
REQ-029 Package arbiter_pkg shall hold the state enum (IDLE, BUSY) and the mode enum (FIXED=0, RR=1).
REQ-030 Selection logic shall be one combinational sub-module, rr_pick (inputs: request_vec, ptr, mode; outputs: index, any), instantiated once.
REQ-031 All outputs shall be driven directly from registers.

Verification
REQ-032 The bench shall use W=4 and MAX_HOLD=8 and cover the following scenarios:
- Idle zero: request_vec=0000 for 3 edges -> error=1, grant_valid=0, granted_idx=0.
- Fixed priority: mode=0, request_vec=1011 -> next cycle granted_idx=3, grant_onehot=1000, error=0; done -> grant_valid=0 one cycle later.
- Round-robin fairness: mode=1, request_vec=1111 held, done pulsed after each grant -> grant sequence 0,1,2,3,0.
- Wrap and skip: mode=1, ptr=3, request_vec=0110 -> granted_idx=1, then ptr=2.
- Timeout: grant 2 held, done never asserted -> release after 8 BUSY cycles, timeout pulse width 1, ptr=3.
- Reset mid-grant: reset asserted while BUSY -> grant_valid=0 without waiting for a clock edge; after release, ptr=0 and the first grant for 1111 in mode 1 is 0.
